// File: rtl/q_pipe_landing.sv
// Receive-end landing queue for a Q_pipe chain: absorbs tokens still in flight after
// back-pressure is raised, and re-emits the stream to the consumer in order.
module q_pipe_landing #(
  parameter int width      = 16,
  parameter int depth      = 16,
  parameter int pipe_depth = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [width-1:0]             i_d,
  input  logic                         i_v,
  output logic                         i_b,
  output logic [width-1:0]             o_d,
  output logic                         o_v,
  input  logic                         o_b,
  output logic [$clog2(depth+1)-1:0]   level,
  output logic                         overflow
);

  localparam int reserve = 2 * pipe_depth + 1;
  localparam int lw      = $clog2(depth + 1);
  localparam int pw      = (depth > 1) ? $clog2(depth) : 1;

  localparam logic [lw-1:0] depth_l  = lw'(depth);
  localparam logic [lw-1:0] thresh_l = lw'(depth - reserve);
  localparam logic [pw-1:0] last_ptr = pw'(depth - 1);

  logic [width-1:0] mem [depth];

  logic [pw-1:0] wr_ptr_reg, wr_ptr_next;
  logic [pw-1:0] rd_ptr_reg, rd_ptr_next;
  logic [lw-1:0] level_reg, level_next;
  logic          i_b_reg;
  logic          overflow_reg;
  logic          push;
  logic          pop;

  // A full queue still accepts a token when the head leaves in the same cycle.
  always_comb begin
    pop         = (level_reg != '0) & ~o_b;
    push        = i_v & ((level_reg < depth_l) | pop);
    level_next  = level_reg + lw'(push) - lw'(pop);
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == last_ptr) ? '0 : wr_ptr_reg + pw'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == last_ptr) ? '0 : rd_ptr_reg + pw'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      i_b_reg      <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      // Threshold leaves room for every token launched before the sender sees i_b.
      i_b_reg      <= (level_next >= thresh_l);
      overflow_reg <= overflow_reg | (i_v & ~push);
    end
  end

  // Storage is not reset; contents are only meaningful below level.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem[wr_ptr_reg] <= i_d;
    end
  end

  assign o_d      = mem[rd_ptr_reg];
  assign o_v      = (level_reg != '0);
  assign i_b      = i_b_reg;
  assign level    = level_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_q_pipe_landing.sv
// Bench for q_pipe_landing: queue-level reference model feeds a scoreboard that a
// negedge monitor drains whenever the DUT hands a token to the consumer.
module tb_q_pipe_landing;

  localparam int WIDTH      = 16;
  localparam int DEPTH      = 16;
  localparam int PIPE_DEPTH = 2;
  localparam int RESERVE    = 2 * PIPE_DEPTH + 1;
  localparam int THRESH     = DEPTH - RESERVE;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] i_d   = '0;
  logic             i_v   = 1'b0;
  logic             i_b;
  logic [WIDTH-1:0] o_d;
  logic             o_v;
  logic             o_b   = 1'b0;
  logic [4:0]       level;
  logic             overflow;

  always #5 clock = ~clock;

  q_pipe_landing #(
    .width      (WIDTH),
    .depth      (DEPTH),
    .pipe_depth (PIPE_DEPTH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_d      (i_d),
    .i_v      (i_v),
    .i_b      (i_b),
    .o_d      (o_d),
    .o_v      (o_v),
    .o_b      (o_b),
    .level    (level),
    .overflow (overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue contents themselves plus the sticky flag and registered i_b.
  logic [WIDTH-1:0] exp_q[$];
  int               m_level = 0;
  bit               m_ovf   = 1'b0;
  bit               m_ib    = 1'b1;
  logic [WIDTH-1:0] mon_exp;

  // Sender plus a PIPE_DEPTH-stage pipe in each direction.
  bit               s_v  [PIPE_DEPTH];
  logic [WIDTH-1:0] s_d  [PIPE_DEPTH];
  bit               s_ib [PIPE_DEPTH];
  int               s_launched = 0;
  int               peak = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && o_v && !o_b) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL o_d: got %0d, expected nothing (scoreboard empty) at t=%0t", o_d, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("pop  o_d=%0d expected=%0d level=%0d", o_d, mon_exp, level);
        check("o_d", int'(o_d), int'(mon_exp));
      end
    end
  end

  // Drive one cycle, advance the model, then compare state after the edge.
  task automatic cycle(input bit rst, input bit iv, input logic [WIDTH-1:0] d, input bit ob);
    bit mpop;
    bit mpush;
    reset = rst;
    i_v   = iv;
    i_d   = d;
    o_b   = ob;
    if (rst) begin
      m_level = 0;
      exp_q.delete();
      m_ovf   = 1'b0;
      m_ib    = 1'b1;
    end else begin
      mpop  = (m_level > 0) && !ob;
      mpush = iv && ((m_level < DEPTH) || mpop);
      if (iv && !mpush) m_ovf = 1'b1;
      if (mpush) exp_q.push_back(d);
      m_level = m_level + int'(mpush) - int'(mpop);
      m_ib    = (m_level >= THRESH);
    end
    @(posedge clock);
    #1;
    check("level", int'(level), m_level);
    check("o_v", int'(o_v), int'(m_level > 0));
    check("i_b", int'(i_b), int'(m_ib));
    check("overflow", int'(overflow), int'(m_ovf));
    if (int'(level) > peak) peak = int'(level);
  endtask

  // Sender honours i_b as seen PIPE_DEPTH cycles late; its tokens land PIPE_DEPTH cycles later.
  task automatic sender_cycle(input bit want, input bit ob, input bit rst);
    bit               pv;
    logic [WIDTH-1:0] pd;
    bit               launch;
    pv     = s_v[PIPE_DEPTH-1];
    pd     = s_d[PIPE_DEPTH-1];
    launch = want && !s_ib[PIPE_DEPTH-1];
    for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
      s_v[k]  = s_v[k-1];
      s_d[k]  = s_d[k-1];
      s_ib[k] = s_ib[k-1];
    end
    s_v[0]  = launch;
    s_d[0]  = WIDTH'($urandom);
    s_ib[0] = m_ib;
    if (launch) s_launched++;
    cycle(rst, pv, pd, ob);
  endtask

  initial begin
    int cyc;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      s_v[k]  = 1'b0;
      s_d[k]  = '0;
      s_ib[k] = 1'b1;
    end

    // 1: reset held with traffic present
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 16'hAAAA, 1'b0);
    reset = 1'b0;
    i_v   = 1'b0;
    #1;
    check("i_b_after_release", int'(i_b), 1);
    cycle(1'b0, 1'b0, '0, 1'b0);

    // 2: continuous stream, consumer always ready
    for (int k = 0; k < 100; k++) cycle(1'b0, 1'b1, WIDTH'(k), 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, 1'b0);

    // 3: fill against a stalled consumer with a well-behaved sender
    peak = 0;
    for (int k = 0; k < 40; k++) sender_cycle(1'b1, 1'b1, 1'b0);
    check("fill_reached_threshold", int'(peak >= THRESH), 1);
    check("fill_peak_within_depth", int'(peak <= DEPTH), 1);
    for (int k = 0; k < 30; k++) sender_cycle(1'b0, 1'b0, 1'b0);

    // 4: sender ignores i_b, overflow becomes sticky
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, WIDTH'(k), 1'b1);
    check("overflow_full_level", int'(level), DEPTH);
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, '0, 1'b0);
    check("overflow_sticky", int'(overflow), 1);
    cycle(1'b1, 1'b0, '0, 1'b0);

    // 5: full queue with simultaneous push and pop
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, 1'b1, WIDTH'(100 + k), 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, WIDTH'(200 + k), 1'b0);
    check("full_simul_level", int'(level), DEPTH);
    for (int k = 0; k < 25; k++) cycle(1'b0, 1'b0, '0, 1'b0);

    // 6: random traffic with a mid-run reset
    s_launched = 0;
    cyc        = 0;
    while (s_launched < 500 && cyc < 5000) begin
      sender_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, cyc == 300);
      cyc++;
    end
    check("random_all_launched", int'(s_launched >= 500), 1);
    for (int k = 0; k < 40; k++) sender_cycle(1'b0, 1'b0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
